// File: rtl/pe_conv_mac_buffer_seq.sv
// ---------------------------------------------------------------------------
// pe_conv_mac_buffer_seq
//
// Input buffer for the convolution MAC processing element. One input
// handshake delivers a complete K x K x C receptive field, which is captured
// into a window register. The window is then replayed to the MAC array as
// KK*NG beats of P channels each, pixel-major (channel group advances first).
//
// Ports
//   clk        : clock
//   rst        : synchronous, active-high reset
//   in_valid   : data_in carries a valid window
//   in_ready   : buffer accepts a window this cycle
//   data_in    : window, pixel p at [(KK-p)*C*DW-1 -: C*DW],
//                channel c of a pixel at relative [(C-c)*DW-1 -: DW]
//   out_valid  : data_out carries a valid beat (FSM state: 0=IDLE, 1=SEND)
//   out_ready  : MAC consumes the beat this cycle
//   data_out   : beat, lane l at [(P-l)*DW-1 -: DW] = channel g*P+l of pixel p
//   out_pixel  : pixel index p of the current beat
//   out_group  : channel group g of the current beat
//   out_last   : current beat is the final beat of the window
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid and its payload stable
// until the transfer; ready may depend combinationally on the other side.
// Here in_ready depends on out_ready so a new window can be accepted on the
// same edge the last beat of the current one leaves (no bubble).
// ---------------------------------------------------------------------------
module pe_conv_mac_buffer_seq #(
  parameter int pDATA_WIDTH     = 8,
  parameter int pKERNEL_SIZE    = 3,
  parameter int pINPUT_CHANNEL  = 4,
  parameter int pINPUT_PARALLEL = 2,
  localparam int KK     = pKERNEL_SIZE * pKERNEL_SIZE,
  localparam int NG     = pINPUT_CHANNEL / pINPUT_PARALLEL,
  localparam int PIX_W  = (KK > 1) ? $clog2(KK) : 1,
  localparam int GRP_W  = (NG > 1) ? $clog2(NG) : 1,
  localparam int WIN_W  = pDATA_WIDTH * pINPUT_CHANNEL * KK,
  localparam int BEAT_W = pDATA_WIDTH * pINPUT_PARALLEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIN_W-1:0]  data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] data_out,
  output logic [PIX_W-1:0]  out_pixel,
  output logic [GRP_W-1:0]  out_group,
  output logic              out_last
);

  // Channel count must split evenly into beats.
  if ((pINPUT_CHANNEL % pINPUT_PARALLEL) != 0) begin : g_bad_parallel
    $error("pe_conv_mac_buffer_seq: pINPUT_CHANNEL must be a multiple of pINPUT_PARALLEL");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   win_q;
  logic [PIX_W-1:0]   pix_q;
  logic [GRP_W-1:0]   grp_q;
  logic               accept;
  logic               xfer;
  int                 beat_lsb;

  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (pix_q == PIX_W'(KK - 1)) && (grp_q == GRP_W'(NG - 1));
  assign in_ready  = !rst && (!out_valid || (out_ready && out_last));
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  assign out_pixel = pix_q;
  if (NG == 1) begin : g_one_group
    assign out_group = '0;
  end else begin : g_groups
    assign out_group = grp_q;
  end

  // Channels g*P .. g*P+P-1 of pixel p are contiguous in the window, so the
  // beat is a single P*DW slice whose LSB sits above all later pixels and
  // all later groups of this pixel.
  always_comb begin
    beat_lsb = ((KK - 1 - int'(pix_q)) * pINPUT_CHANNEL
               + (NG - 1 - int'(grp_q)) * pINPUT_PARALLEL) * pDATA_WIDTH;
    data_out = BEAT_W'(win_q >> beat_lsb);
  end

  // FSM next state. A last-beat transfer with a simultaneous accept stays in
  // SEND so the next window starts without a gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (xfer && out_last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Window and beat counters. The window is written only on accept; beat
  // transfers move the counters alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      pix_q <= '0;
      grp_q <= '0;
    end else if (accept) begin
      win_q <= data_in;
      pix_q <= '0;
      grp_q <= '0;
    end else if (xfer) begin
      if (out_last) begin
        pix_q <= '0;
        grp_q <= '0;
      end else if (grp_q == GRP_W'(NG - 1)) begin
        grp_q <= '0;
        pix_q <= pix_q + PIX_W'(1);
      end else begin
        grp_q <= grp_q + GRP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_conv_mac_buffer_seq.sv
// ---------------------------------------------------------------------------
// tb_pe_conv_mac_buffer_seq
//
// Three instances: u0 default (K=3,C=4,P=2), u1 (K=3,C=4,P=4) and
// u2 (K=1,C=1,P=1). Element for pixel p, channel c of a window with base b
// is (b + 16*p + c) mod 256. A window-level model (pending window base plus
// beat number) predicts every output each cycle; literal "pins" posted by
// the driver are checked by the same compare process.
// ---------------------------------------------------------------------------
module tb_pe_conv_mac_buffer_seq;

  localparam int KK_A[3] = '{9, 9, 1};
  localparam int NG_A[3] = '{2, 1, 1};
  localparam int P_A[3]  = '{2, 4, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- stimulus signals ----------------
  logic iv[3];
  logic ordy[3];
  int   ibase[3];
  bit   chk_en;

  function automatic logic [287:0] mk_win9(int b);
    logic [287:0] w;
    w = '0;
    for (int p = 0; p < 9; p++)
      for (int c = 0; c < 4; c++)
        w[(9 - p) * 32 - c * 8 - 1 -: 8] = 8'(b + 16 * p + c);
    return w;
  endfunction

  logic [287:0] din0, din1;
  logic [7:0]   din2;
  assign din0 = mk_win9(ibase[0]);
  assign din1 = mk_win9(ibase[1]);
  assign din2 = 8'(ibase[2]);

  // ---------------- DUTs ----------------
  logic [15:0] d0; logic [3:0] px0; logic g0; logic v0, r0, l0;
  logic [31:0] d1; logic [3:0] px1; logic g1; logic v1, r1, l1;
  logic [7:0]  d2; logic px2;       logic g2; logic v2, r2, l2;

  pe_conv_mac_buffer_seq u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(r0), .data_in(din0),
    .out_valid(v0), .out_ready(ordy[0]), .data_out(d0), .out_pixel(px0),
    .out_group(g0), .out_last(l0)
  );

  pe_conv_mac_buffer_seq #(.pINPUT_PARALLEL(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(r1), .data_in(din1),
    .out_valid(v1), .out_ready(ordy[1]), .data_out(d1), .out_pixel(px1),
    .out_group(g1), .out_last(l1)
  );

  pe_conv_mac_buffer_seq #(.pKERNEL_SIZE(1), .pINPUT_CHANNEL(1), .pINPUT_PARALLEL(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(r2), .data_in(din2),
    .out_valid(v2), .out_ready(ordy[2]), .data_out(d2), .out_pixel(px2),
    .out_group(g2), .out_last(l2)
  );

  logic [31:0] a_data[3], a_pix[3], a_grp[3];
  logic        a_last[3], a_valid[3], a_ready[3];
  assign a_data[0] = 32'(d0);  assign a_pix[0] = 32'(px0); assign a_grp[0] = 32'(g0);
  assign a_data[1] = d1;       assign a_pix[1] = 32'(px1); assign a_grp[1] = 32'(g1);
  assign a_data[2] = 32'(d2);  assign a_pix[2] = 32'(px2); assign a_grp[2] = 32'(g2);
  assign a_last[0] = l0; assign a_valid[0] = v0; assign a_ready[0] = r0;
  assign a_last[1] = l1; assign a_valid[1] = v1; assign a_ready[1] = r1;
  assign a_last[2] = l2; assign a_valid[2] = v2; assign a_ready[2] = r2;

  // ---------------- literal pins (driver writes, compare reads) ----------------
  // kind = instance*8 + field; field 0 data,1 pixel,2 group,3 last,4 valid,
  // 5 in_ready, 6 DUT transfer count
  string       pin_nm[128];
  int          pin_kind[128];
  logic [31:0] pin_exp[128];
  int          pin_n;
  int          pin_rd;

  task automatic pin(string nm, int kind, logic [31:0] exp);
    pin_nm[pin_n]   = nm;
    pin_kind[pin_n] = kind;
    pin_exp[pin_n]  = exp;
    pin_n++;
  endtask

  // ---------------- scoreboard / model ----------------
  int n_tests;
  int n_fail;
  bit mv[3];          // a window is being replayed
  int mbase[3];       // base of the window being replayed
  int bi[3];          // beat number within the window
  bit win_dirty[3];   // window register holds non-reset data
  int dut_xfers[3];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int total, ep, eg, f, k;
    bit er, el, acc, xf;
    logic [31:0] ed, act;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        total = KK_A[i] * NG_A[i];
        er = !rst && (!mv[i] || (ordy[i] && bi[i] == total - 1));
        check($sformatf("u%0d_in_ready", i), 32'(a_ready[i]), 32'(er));
        check($sformatf("u%0d_out_valid", i), 32'(a_valid[i]), 32'(mv[i]));
        if (mv[i]) begin
          ep = bi[i] / NG_A[i];
          eg = bi[i] % NG_A[i];
          el = (bi[i] == total - 1);
          ed = '0;
          for (int l = 0; l < P_A[i]; l++)
            ed[(P_A[i] - l) * 8 - 1 -: 8] = 8'(mbase[i] + 16 * ep + eg * P_A[i] + l);
          check($sformatf("u%0d_data_b%0d", i, bi[i]), a_data[i], ed);
          check($sformatf("u%0d_pixel_b%0d", i, bi[i]), a_pix[i], 32'(ep));
          check($sformatf("u%0d_group_b%0d", i, bi[i]), a_grp[i], 32'(eg));
          check($sformatf("u%0d_last_b%0d", i, bi[i]), 32'(a_last[i]), 32'(el));
        end else begin
          check($sformatf("u%0d_last_idle", i), 32'(a_last[i]), 32'd0);
          if (!win_dirty[i]) begin
            check($sformatf("u%0d_data_clear", i), a_data[i], 32'd0);
            check($sformatf("u%0d_pixel_clear", i), a_pix[i], 32'd0);
            check($sformatf("u%0d_group_clear", i), a_grp[i], 32'd0);
          end
        end
        if (!rst && a_valid[i] && ordy[i]) dut_xfers[i]++;
        // model advance for the coming edge
        if (rst) begin
          mv[i] = 1'b0;
          bi[i] = 0;
          win_dirty[i] = 1'b0;
        end else begin
          acc = iv[i] && er;
          xf  = mv[i] && ordy[i];
          if (xf) begin
            if (bi[i] == total - 1) begin
              mv[i] = 1'b0;
              bi[i] = 0;
            end else begin
              bi[i]++;
            end
          end
          if (acc) begin
            mv[i] = 1'b1;
            bi[i] = 0;
            mbase[i] = ibase[i];
            win_dirty[i] = 1'b1;
          end
        end
      end
      while (pin_rd < pin_n) begin
        k = pin_kind[pin_rd] / 8;
        f = pin_kind[pin_rd] % 8;
        case (f)
          0: act = a_data[k];
          1: act = a_pix[k];
          2: act = a_grp[k];
          3: act = 32'(a_last[k]);
          4: act = 32'(a_valid[k]);
          5: act = 32'(a_ready[k]);
          default: act = 32'(dut_xfers[k]);
        endcase
        check(pin_nm[pin_rd], act, pin_exp[pin_rd]);
        pin_rd++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int x0;
    rst = 1'b1;
    chk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
      ibase[i] = 0;
    end
    tick();
    tick();
    chk_en = 1'b1;
    pin("rst_valid", 4, 0);
    pin("rst_in_ready", 5, 0);
    pin("rst_data", 0, 0);
    tick();
    rst = 1'b0;
    pin("post_rst_in_ready", 5, 1);

    // 1: single window, out_ready held high
    iv[0] = 1'b1; ibase[0] = 0;
    tick();
    iv[0] = 1'b0;
    pin("t1_b0_data", 0, 32'h0001); pin("t1_b0_pix", 1, 0); pin("t1_b0_grp", 2, 0);
    tick();
    pin("t1_b1_data", 0, 32'h0203); pin("t1_b1_grp", 2, 1);
    tick();
    pin("t1_b2_data", 0, 32'h1011); pin("t1_b2_pix", 1, 1); pin("t1_b2_grp", 2, 0);
    repeat (15) tick();
    pin("t1_b17_data", 0, 32'h8283); pin("t1_b17_pix", 1, 8);
    pin("t1_b17_grp", 2, 1); pin("t1_b17_last", 3, 1);
    tick();
    pin("t1_end_valid", 4, 0);

    // 2: backpressure at beat 5
    x0 = dut_xfers[0];
    iv[0] = 1'b1; ibase[0] = 0;
    tick();
    iv[0] = 1'b0;
    repeat (5) tick();
    ordy[0] = 1'b0;
    repeat (3) begin
      pin("t2_hold_data", 0, 32'h2223); pin("t2_hold_pix", 1, 2); pin("t2_hold_grp", 2, 1);
      tick();
    end
    ordy[0] = 1'b1;
    repeat (13) tick();
    pin("t2_xfer_count", 6, 32'(x0 + 18));
    pin("t2_end_valid", 4, 0);

    // 3: back-to-back windows with in_valid held high
    iv[0] = 1'b1; ibase[0] = 0;
    tick();
    ibase[0] = 8'h80;
    repeat (17) begin
      pin("t3_busy_in_ready", 5, 0);
      tick();
    end
    pin("t3_last_in_ready", 5, 1); pin("t3_last", 3, 1);
    tick();
    iv[0] = 1'b0;
    pin("t3_w2_b0_data", 0, 32'h8081); pin("t3_w2_valid", 4, 1); pin("t3_w2_pix", 1, 0);
    repeat (18) tick();
    pin("t3_end_valid", 4, 0);

    // 4: foreign window offered while busy
    iv[0] = 1'b1; ibase[0] = 0;
    tick();
    for (int b = 0; b < 18; b++) begin
      if (b >= 3 && b <= 10) begin
        iv[0] = 1'b1; ibase[0] = 8'h55;
      end else begin
        iv[0] = 1'b0;
      end
      tick();
    end
    ibase[0] = 0;
    pin("t4_end_valid", 4, 0);

    // 5: reset in the middle of a window
    iv[0] = 1'b1; ibase[0] = 8'h30;
    tick();
    iv[0] = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pin("t5_valid", 4, 0); pin("t5_data", 0, 0); pin("t5_in_ready", 5, 1); pin("t5_pix", 1, 0);
    iv[0] = 1'b1; ibase[0] = 0;
    tick();
    iv[0] = 1'b0;
    pin("t5_b0_data", 0, 32'h0001); pin("t5_b0_pix", 1, 0);
    pin("t5_b0_grp", 2, 0); pin("t5_b0_valid", 4, 1);
    repeat (18) tick();
    pin("t5_end_valid", 4, 0);

    // 6a: P = C = 4
    iv[1] = 1'b1; ibase[1] = 0;
    tick();
    iv[1] = 1'b0;
    pin("t6a_b0_data", 8, 32'h00010203); pin("t6a_b0_grp", 10, 0);
    repeat (8) tick();
    pin("t6a_b8_data", 8, 32'h80818283); pin("t6a_b8_last", 11, 1); pin("t6a_b8_grp", 10, 0);
    tick();
    pin("t6a_end_valid", 12, 0);

    // 6b: K = 1, C = P = 1, one beat per window with overlapping accepts
    iv[2] = 1'b1; ibase[2] = 8'h10;
    tick();
    pin("t6b_w0_data", 16, 32'h10); pin("t6b_w0_last", 19, 1);
    for (int k = 1; k < 4; k++) begin
      pin("t6b_overlap_in_ready", 21, 1);
      pin("t6b_last", 19, 1);
      ibase[2] = 8'h10 + k;
      tick();
      pin("t6b_data", 16, 32'(8'h10 + k));
    end
    iv[2] = 1'b0;
    tick();
    pin("t6b_end_valid", 20, 0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_conv_mac_buffer_seq.md
Name: pe_conv_mac_buffer_seq

Overview:
- Next-generation input buffer for the convolution MAC processing element.
- Captures one full K×K×C receptive field per input handshake into a window register.
- Replays the window to the MAC array as a sequence of beats, pINPUT_PARALLEL channels per beat, walking pixels and channel groups with internal counters.
- Uses valid/ready handshakes on both sides, with zero-bubble overlap between consecutive windows.

Parameters:
- pDATA_WIDTH, 8: bits per activation element.
- pKERNEL_SIZE, 3: kernel side K; the window holds KK = K*K pixels.
- pINPUT_CHANNEL, 4: channels per pixel (C).
- pINPUT_PARALLEL, 2: channels emitted per beat (P). C mod P must be 0; violations are flagged at elaboration. NG = C/P channel groups.

Ports:
- clk        in   1                 clock
- rst        in   1                 synchronous, active-high reset
- in_valid   in   1                 data_in carries a valid window
- in_ready   out  1                 buffer can accept a window this cycle
- data_in    in   DW*C*KK           window; pixel p at bits [(KK-p)*C*DW-1 -: C*DW]; within a pixel, channel c at relative bits [(C-c)*DW-1 -: DW]
- out_valid  out  1                 data_out carries a valid beat
- out_ready  in   1                 MAC consumes the beat this cycle
- data_out   out  DW*P              beat; lane l at [(P-l)*DW-1 -: DW] = channel g*P+l of pixel p
- out_pixel  out  clog2(KK)         pixel index p of the current beat
- out_group  out  max(1,clog2(NG))  channel group g of the current beat
- out_last   out  1                 current beat is the final beat of the window (p==KK-1 and g==NG-1)

Behaviour:
- **State:** IDLE (out_valid=0) and SEND (out_valid=1), held in a registered out_valid flag, plus registered counters pix_cnt and grp_cnt.
- **Output path:** data_out is a mux of the window register indexed by the counters. There is no combinational path from data_in to any output.
- **Reset:**
  - State goes to IDLE; out_valid=0.
  - pix_cnt=0, grp_cnt=0, window register=0, so data_out=0, out_pixel=0, out_group=0, out_last=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
- **in_ready:** = !rst && (!out_valid || (out_ready && out_last)). This is combinational from out_ready, which allows overlap on the last beat.
- **Accept:** occurs when in_valid && in_ready at an edge. On that edge:
  - the window register loads data_in;
  - counters go to 0;
  - out_valid goes to 1.
  - Beat 0 is therefore visible in the cycle after accept (latency 1).
- **Beat transfer:** occurs when out_valid && out_ready. Order is pixel-major: grp_cnt increments first; when it wraps NG-1→0, pix_cnt increments. A window is KK*NG beats.
- **Last beat transfer:**
  - With a simultaneous accept: reload the window, counters go to 0, out_valid stays 1 (no bubble).
  - Otherwise: out_valid goes to 0 (IDLE) and counters go to 0.
- **Backpressure:** while out_valid && !out_ready, the counters, window, data_out, out_pixel, out_group and out_last are all held stable. in_ready=0 unless the held beat is the last beat and out_ready is high.
- **Busy input:** in_valid while in_ready=0 is ignored; the window register is unchanged.
- **Degenerate cases:**
  - NG=1: grp_cnt is a constant 0 and out_group is tied to 0.
  - KK*NG=1: every beat is a last beat.
- **Reset mid-window:** aborts the window; the remaining beats are discarded and the reset state applies on the next cycle.
- **Data integrity:** the window register is written only on accept, never on a beat transfer.

Test Plan:
Default parameters; stimulus element for pixel p, channel c = 16*p + c.
1. Single window, out_ready=1: accept at cycle 0 → cycles 1..18 give 18 beats. Beat 0 = {0x00,0x01} p0 g0; beat 1 = {0x02,0x03} p0 g1; beat 2 = {0x10,0x11} p1 g0; beat 17 = {0x82,0x83} p8 g1 with out_last=1. out_valid=0 at cycle 19.
2. Backpressure: deassert out_ready for 3 cycles at beat 5 → data_out={0x22,0x23}, out_pixel=2, out_group=1 held for all 3 cycles. Sequence resumes intact, total 18 transfers.
3. Back-to-back windows, second window = first + 0x80 per element, in_valid held high → in_ready pulses only on the beat-17 cycle. Beat 0 of window 2 = {0x80,0x81} on the very next cycle; out_valid never drops.
4. in_valid with a different window during beats 3..10 → ignored; all 18 beats match the first window.
5. rst asserted at beat 7 for 1 cycle → next cycle out_valid=0, data_out=0, in_ready=1. A new window then starts again at beat 0 p0 g0.
6. Parameter sweep P=C=4: 9 beats, beat 0 = {0x00,0x01,0x02,0x03}, out_group=0 throughout. Also K=1, C=P=1: every beat has out_last=1 and in_ready overlaps each transfer.
